// File: rtl/ext_mem_responder_if.sv
// Initiator-side bus of the external memory responder: request, write data, response.
// Latency: none (wires only).
// Backpressure: none on the bus itself; the responder holds off new requests while busy.
interface ext_mem_responder_if #(
    parameter int WORD_SIZE = 32
);
    logic [31:0]          mem_addr;
    logic                 en_ext_mem_re;
    logic                 en_ext_mem_wr;
    logic [WORD_SIZE-1:0] data_in;
    logic [WORD_SIZE-1:0] data_out;
    logic                 mem_ready;
    logic                 addr_err;
    logic                 busy;

    modport master (
        output mem_addr, en_ext_mem_re, en_ext_mem_wr, data_in,
        input  data_out, mem_ready, addr_err, busy
    );

    modport slave (
        input  mem_addr, en_ext_mem_re, en_ext_mem_wr, data_in,
        output data_out, mem_ready, addr_err, busy
    );
endinterface

// File: rtl/ext_mem_responder.sv
// Word-addressed memory model answering single read/write requests with a one-cycle mem_ready.
// Latency: READ_LATENCY / WRITE_LATENCY edges from acceptance to acknowledge.
// Backpressure: busy from acceptance through ACK; requests outside IDLE are ignored.
module ext_mem_responder #(
    parameter int WORD_SIZE     = 32,
    parameter int DEPTH_WORDS   = 1024,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    ext_mem_responder_if.slave bus
);
    localparam int          IW   = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  RCNT = 4'(READ_LATENCY - 1);
    localparam logic [3:0]  WCNT = 4'(WRITE_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t               state;
    logic [3:0]           cnt;
    logic                 op_wr;
    logic [31:2]          addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [WORD_SIZE-1:0] rdata_q;
    logic                 ready_q;
    logic                 err_q;
    logic                 busy_q;
    logic [WORD_SIZE-1:0] mem [DEPTH_WORDS];

    logic [IW-1:0] idx;
    logic          oor;
    logic          unused_byte_offset;

    assign idx = addr_q[2 +: IW];
    // Any address bit above the word index makes the access out of range.
    assign oor = (addr_q >> IW) != 30'd0;
    assign unused_byte_offset = ^bus.mem_addr[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            op_wr   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.en_ext_mem_re || bus.en_ext_mem_wr) begin
                        op_wr   <= bus.en_ext_mem_wr;
                        addr_q  <= bus.mem_addr[31:2];
                        wdata_q <= bus.data_in;
                        cnt     <= bus.en_ext_mem_wr ? WCNT : RCNT;
                        busy_q  <= 1'b1;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state   <= ACK;
                        ready_q <= 1'b1;
                        err_q   <= oor;
                        rdata_q <= (!op_wr && !oor) ? mem[idx] : '0;
                    end
                end
                ACK: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                    busy_q  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is deliberately outside the reset domain; reset forces IDLE so no write can fire.
    always_ff @(posedge clk) begin
        if (state == BUSY && cnt == 4'd0 && op_wr && !oor) begin
            mem[idx] <= wdata_q;
        end
    end

    assign bus.data_out  = rdata_q;
    assign bus.mem_ready = ready_q;
    assign bus.addr_err  = err_q;
    assign bus.busy      = busy_q;
endmodule
